// File: rtl/microprogram_sequencer_pkg.sv
// Shared encodings for the microprogram sequencer: widths, ns_sel and
// cond_sel codes, dispatched opcodes and their microstore entry states.
package microprogram_sequencer_pkg;

  localparam int unsigned STATE_W  = 7;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned NS_SEL_W = 3;
  localparam int unsigned COND_W   = 2;

  // next-state modes
  localparam logic [NS_SEL_W-1:0] NS_DISPATCH = 3'd0;
  localparam logic [NS_SEL_W-1:0] NS_INC      = 3'd1;
  localparam logic [NS_SEL_W-1:0] NS_JUMP     = 3'd2;
  localparam logic [NS_SEL_W-1:0] NS_BRANCH   = 3'd3;
  localparam logic [NS_SEL_W-1:0] NS_WAIT     = 3'd4;

  // condition sources
  localparam logic [COND_W-1:0] COND_MOC   = 2'd0;
  localparam logic [COND_W-1:0] COND_ZERO  = 2'd1;
  localparam logic [COND_W-1:0] COND_NEG   = 2'd2;
  localparam logic [COND_W-1:0] COND_TRUE  = 2'd3;

  // opcodes recognised by dispatch
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;

  // microstore entry point of each instruction class
  localparam logic [STATE_W-1:0] DS_RTYPE = 7'd2;
  localparam logic [STATE_W-1:0] DS_ADDI  = 7'd3;
  localparam logic [STATE_W-1:0] DS_LW    = 7'd6;
  localparam logic [STATE_W-1:0] DS_SW    = 7'd11;
  localparam logic [STATE_W-1:0] DS_BEQ   = 7'd16;
  localparam logic [STATE_W-1:0] DS_J     = 7'd18;

endpackage

// File: rtl/microprogram_sequencer_encoder.sv
// Opcode dispatch table: maps IR[31:26] to the first microstore state of
// that instruction class; unknown opcodes fall back to the reset state.
module opcode_dispatch_encoder
  import microprogram_sequencer_pkg::*;
#(
  parameter int unsigned RESET_STATE = 0
) (
  input  logic [5:0] opcode,
  output logic [6:0] target
);

  // combinational opcode lookup
  always_comb begin
    target = STATE_W'(RESET_STATE);
    case (opcode)
      OP_RTYPE: target = DS_RTYPE;
      OP_ADDI:  target = DS_ADDI;
      OP_LW:    target = DS_LW;
      OP_SW:    target = DS_SW;
      OP_BEQ:   target = DS_BEQ;
      OP_J:     target = DS_J;
      default:  target = STATE_W'(RESET_STATE);
    endcase
  end

endmodule

// File: rtl/microprogram_sequencer.sv
// Microprogram next-state sequencer: holds the control state (microstore
// address) and selects dispatch / increment / jump / branch / wait-for-MOC.
// Optional feature macro: SEQ_MOC_TIMEOUT_EN (bounded MOC wait with sticky
// timeout_err); without it the wait is unbounded and timeout_err is 0.
module microprogram_sequencer
  import microprogram_sequencer_pkg::*;
#(
  parameter int unsigned RESET_STATE    = 0,
  parameter int unsigned MAX_STATE      = 19,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [2:0] ns_sel,
  input  logic [1:0] cond_sel,
  input  logic       cond_inv,
  input  logic [6:0] cr_addr,
  input  logic       moc,
  input  logic       alu_zero,
  input  logic       alu_neg,
  output logic [6:0] state,
  output logic       wait_moc,
  output logic       timeout_err
);

  localparam logic [STATE_W-1:0] RST_S = STATE_W'(RESET_STATE);
  localparam logic [STATE_W-1:0] MAX_S = STATE_W'(MAX_STATE);

  logic [STATE_W-1:0] dispatch_state;
  logic [STATE_W-1:0] inc_state;
  logic [STATE_W-1:0] target;
  logic [STATE_W-1:0] next_state;
  logic               cond_raw;
  logic               cond;
  logic               timeout_hit;

  opcode_dispatch_encoder #(
    .RESET_STATE(RESET_STATE)
  ) u_encoder (
    .opcode(opcode),
    .target(dispatch_state)
  );

  // stall indication; forced low while reset is asserted
  assign wait_moc = !reset && (ns_sel == NS_WAIT) && !moc;

`ifdef SEQ_MOC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign timeout_hit = wait_moc && (wait_cnt == CNT_LIMIT);
  assign timeout_err = err_q;

  // count consecutive stalled cycles; latch the error when the limit is hit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (timeout_hit) begin
      wait_cnt <= '0;
      err_q    <= 1'b1;
    end else if (wait_moc) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // next-state selection from the current microinstruction's fields
  always_comb begin
    cond_raw   = 1'b0;
    target     = RST_S;
    next_state = RST_S;
    inc_state  = state + STATE_W'(1);

    case (cond_sel)
      COND_MOC:  cond_raw = moc;
      COND_ZERO: cond_raw = alu_zero;
      COND_NEG:  cond_raw = alu_neg;
      default:   cond_raw = 1'b1;
    endcase
    cond = cond_raw ^ cond_inv;

    case (ns_sel)
      NS_DISPATCH: target = dispatch_state;
      NS_INC:      target = inc_state;
      NS_JUMP:     target = cr_addr;
      NS_BRANCH:   target = cond ? cr_addr : inc_state;
      NS_WAIT:     target = moc ? inc_state : state;
      default:     target = RST_S;
    endcase

    // unimplemented targets (including increment past the top) restart
    next_state = (target > MAX_S) ? RST_S : target;
    if (timeout_hit) next_state = RST_S;
  end

  // control state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST_S;
    else       state <= next_state;
  end

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Self-checking bench for microprogram_sequencer: directed scenarios plus
// randomized microinstructions compared against a behavioural model.
// Define SEQ_MOC_TIMEOUT_EN for both bench and RTL to cover the timeout.
module tb_microprogram_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [2:0] ns_sel;
  logic [1:0] cond_sel;
  logic       cond_inv;
  logic [6:0] cr_addr;
  logic       moc;
  logic       alu_zero;
  logic       alu_neg;
  logic [6:0] state;
  logic       wait_moc;
  logic       timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int exp_state = 0;
  int exp_cnt   = 0;
  int exp_err   = 0;

  microprogram_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ns_sel(ns_sel),
    .cond_sel(cond_sel), .cond_inv(cond_inv), .cr_addr(cr_addr),
    .moc(moc), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .state(state), .wait_moc(wait_moc), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int enc(input int op);
    case (op)
      'h00: return 2;
      'h08: return 3;
      'h23: return 6;
      'h2B: return 11;
      'h04: return 16;
      'h02: return 18;
      default: return 0;
    endcase
  endfunction

  // advance the model by one clock using the currently driven inputs
  task automatic model_clock();
    int c, tgt;
    bit stalled;
    case (int'(cond_sel))
      0: c = int'(moc);
      1: c = int'(alu_zero);
      2: c = int'(alu_neg);
      default: c = 1;
    endcase
    c = c ^ int'(cond_inv);
    case (int'(ns_sel))
      0: tgt = enc(int'(opcode));
      1: tgt = exp_state + 1;
      2: tgt = int'(cr_addr);
      3: tgt = (c != 0) ? int'(cr_addr) : exp_state + 1;
      4: tgt = moc ? exp_state + 1 : exp_state;
      default: tgt = 0;
    endcase
    if (tgt > 19) tgt = 0;
    stalled = (ns_sel == 3'd4) && !moc;
`ifdef SEQ_MOC_TIMEOUT_EN
    if (stalled && exp_cnt == 15) begin
      tgt = 0; exp_err = 1; exp_cnt = 0;
    end else if (stalled) exp_cnt++;
    else exp_cnt = 0;
`endif
    exp_state = tgt;
  endtask

  // drive one microinstruction, check wait_moc, clock, check state/error
  task automatic step(input string tag, input int ns, input int cs, input int ci,
                      input int cr, input int op, input int m, input int az, input int an);
    ns_sel = 3'(ns); cond_sel = 2'(cs); cond_inv = 1'(ci); cr_addr = 7'(cr);
    opcode = 6'(op); moc = 1'(m); alu_zero = 1'(az); alu_neg = 1'(an);
    #1;
    check_eq({tag, ".wait_moc"}, int'(wait_moc), (ns == 4 && m == 0) ? 1 : 0);
    model_clock();
    @(posedge clk); #1;
    check_eq({tag, ".state"}, int'(state), exp_state);
    check_eq({tag, ".err"}, int'(timeout_err), exp_err);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("reset.state", int'(state), 0);
    check_eq("reset.wait_moc", int'(wait_moc), 0);
    check_eq("reset.err", int'(timeout_err), 0);
    reset = 1'b0;
    exp_state = 0; exp_cnt = 0; exp_err = 0;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; ns_sel = 3'd1; cond_sel = '0; cond_inv = 1'b0;
    cr_addr = '0; moc = 1'b0; alu_zero = 1'b0; alu_neg = 1'b0;
    #23;
    check_eq("por.state", int'(state), 0);
    do_reset();

    // asynchronous reset in the middle of a MOC wait at state 7
    step("jump7", 2, 0, 0, 7, 0, 0, 0, 0);
    step("wait7", 4, 0, 0, 0, 0, 0, 0, 0);
    ns_sel = 3'd4; moc = 1'b0;
    #1;
    check_eq("midwait.wait_moc", int'(wait_moc), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("async.state", int'(state), 0);
    check_eq("async.wait_moc", int'(wait_moc), 0);
    check_eq("async.err", int'(timeout_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_state = 0; exp_cnt = 0; exp_err = 0;

    // dispatch
    step("disp_lw", 0, 0, 0, 0, 'h23, 0, 0, 0);
    step("disp_sw", 0, 0, 0, 0, 'h2B, 0, 0, 0);
    step("disp_bad", 0, 0, 0, 0, 'h3F, 0, 0, 0);
    step("disp_j", 0, 0, 0, 0, 'h02, 0, 0, 0);

    // conditional branch on alu_zero, normal and inverted
    step("jump4a", 2, 0, 0, 4, 0, 0, 0, 0);
    step("br_taken", 3, 1, 0, 12, 0, 0, 1, 0);
    step("jump4b", 2, 0, 0, 4, 0, 0, 0, 0);
    step("br_inv", 3, 1, 1, 12, 0, 0, 1, 0);

    // wait three cycles, then moc
    for (int i = 0; i < 3; i++) step("wait_hold", 4, 0, 0, 0, 0, 0, 0, 0);
    step("wait_go", 4, 0, 0, 0, 0, 1, 0, 0);

    // range boundaries
    step("jump19", 2, 0, 0, 19, 0, 0, 0, 0);
    step("inc_wrap", 1, 0, 0, 0, 0, 0, 0, 0);
    step("jump_oob", 2, 0, 0, 40, 0, 0, 0, 0);
    step("jump5", 2, 0, 0, 5, 0, 0, 0, 0);
    step("reserved", 6, 0, 0, 0, 0, 0, 0, 0);

`ifdef SEQ_MOC_TIMEOUT_EN
    // timeout after 16 stalled cycles, sticky error
    step("to_jump", 2, 0, 0, 9, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step("to_wait", 4, 0, 0, 0, 0, 0, 0, 0);
    check_eq("to.state0", int'(state), 0);
    check_eq("to.err_set", int'(timeout_err), 1);
    step("to_sticky", 1, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    // moc arriving on the limit cycle wins
    step("tm_jump", 2, 0, 0, 9, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) step("tm_wait", 4, 0, 0, 0, 0, 0, 0, 0);
    step("tm_moc", 4, 0, 0, 0, 0, 1, 0, 0);
    check_eq("tm.state10", int'(state), 10);
    check_eq("tm.no_err", int'(timeout_err), 0);
`endif

    // randomized microinstructions
    for (int i = 0; i < 400; i++) begin
      int ns, op;
      ns = ($urandom_range(0, 9) < 4) ? 4 : int'($urandom_range(0, 7));
      op = ($urandom_range(0, 1) == 1) ? enc_pick($urandom_range(0, 5)) : int'($urandom_range(0, 63));
      step("rand", ns, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 24)), op, int'($urandom_range(0, 2) == 0),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  function automatic int enc_pick(input int unsigned k);
    case (k)
      0: return 'h00;
      1: return 'h08;
      2: return 'h23;
      3: return 'h2B;
      4: return 'h04;
      default: return 'h02;
    endcase
  endfunction

endmodule
